// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Purpose:
//   Program counter sequencer for a simple processor front end. Each rising
//   clock edge selects the next PC. The priority order is stall, return,
//   call, jump, taken branch, and then increment. The PC is registered, so
//   a request shows up on program_counter one cycle after it is sampled.
//
// Configuration macro:
//   PC_SEQUENCER_STACK_EN
//     Defined   : a return stack of STACK_DEPTH entries is built. A call
//                 pushes PC+1 and a return pops it. The overflow and
//                 underflow flags are sticky until reset.
//     Undefined : no stack storage is built. call_en acts as a jump and
//                 ret_en acts as an increment. stack_count and both flags
//                 are tied to 0.
//
// Parameters:
//   WIDTH        program counter width in bits
//   STACK_DEPTH  number of return-stack entries (>= 1)
//   RESET_VECTOR PC value loaded on reset
//
// Ports:
//   clk              rising-edge clock
//   is_powered_on    synchronous active-low reset (0 = reset)
//   stall            hold PC, stack and flags
//   jump_en          absolute jump to jump_target
//   jump_target      absolute target for jump and call
//   branch_en        relative branch request
//   branch_taken     branch condition result
//   branch_offset    two's-complement branch offset
//   call_en          push return address and go to jump_target
//   ret_en           pop return address into PC
//   program_counter  registered current PC
//   stack_count      number of valid stack entries
//   stack_overflow   sticky: call issued with the stack full
//   stack_underflow  sticky: return issued with the stack empty
// ---------------------------------------------------------------------------
module pc_sequencer #(
    parameter int               WIDTH        = 16,
    parameter int               STACK_DEPTH  = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                             clk,
    input  logic                             is_powered_on,
    input  logic                             stall,
    input  logic                             jump_en,
    input  logic [WIDTH-1:0]                 jump_target,
    input  logic                             branch_en,
    input  logic                             branch_taken,
    input  logic [WIDTH-1:0]                 branch_offset,
    input  logic                             call_en,
    input  logic                             ret_en,
    output logic [WIDTH-1:0]                 program_counter,
    output logic [$clog2(STACK_DEPTH+1)-1:0] stack_count,
    output logic                             stack_overflow,
    output logic                             stack_underflow
);

    localparam int CW = $clog2(STACK_DEPTH + 1);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pcInc;
    logic [WIDTH-1:0] w_branchTarget;

    // Both adds wrap modulo 2^WIDTH. A two's-complement offset needs no
    // explicit sign extension, because it is already WIDTH bits wide.
    assign w_pcInc        = r_pc + 1'b1;
    assign w_branchTarget = r_pc + branch_offset;

    assign program_counter = r_pc;

`ifdef PC_SEQUENCER_STACK_EN

    // The pointer width is at least 1 bit, so a single-entry stack still
    // has a legal index.
    localparam int PW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [WIDTH-1:0] r_stack [STACK_DEPTH];
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_full;
    logic             w_empty;
    logic [PW-1:0]    w_pushIdx;
    logic [PW-1:0]    w_popIdx;
    logic             w_push;

    assign w_full    = (r_count == CW'(STACK_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_pushIdx = PW'(r_count);
    assign w_popIdx  = PW'(r_count - CW'(1));

    // A push happens only when the call is the winning request and there is
    // room left. An overflowing call still jumps, but it leaves the stack
    // untouched.
    assign w_push = is_powered_on && !stall && !ret_en && call_en && !w_full;

    // The stack storage has no reset. An entry is only read when
    // stack_count says it is valid, so stale contents cannot leak out.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[w_pushIdx] <= w_pcInc;
        end
    end

    // Next-PC selection and stack bookkeeping. Reset wins over everything,
    // including stall. Reset also empties the stack logically, which
    // discards any pending return addresses.
    always_ff @(posedge clk) begin
        if (!is_powered_on) begin
            r_pc        <= RESET_VECTOR;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (!stall) begin
            if (ret_en) begin
                if (w_empty) begin
                    r_pc        <= w_pcInc;
                    r_underflow <= 1'b1;
                end else begin
                    r_pc    <= r_stack[w_popIdx];
                    r_count <= r_count - CW'(1);
                end
            end else if (call_en) begin
                r_pc <= jump_target;
                if (w_full) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_count <= r_count + CW'(1);
                end
            end else if (jump_en) begin
                r_pc <= jump_target;
            end else if (branch_en && branch_taken) begin
                r_pc <= w_branchTarget;
            end else begin
                r_pc <= w_pcInc;
            end
        end
    end

    assign stack_count     = r_count;
    assign stack_overflow  = r_overflow;
    assign stack_underflow = r_underflow;

`else

    // Build without a stack. A return falls through to an increment at the
    // return's priority slot. A call is a plain jump at the call's slot.
    always_ff @(posedge clk) begin
        if (!is_powered_on) begin
            r_pc <= RESET_VECTOR;
        end else if (!stall) begin
            if (ret_en) begin
                r_pc <= w_pcInc;
            end else if (call_en || jump_en) begin
                r_pc <= jump_target;
            end else if (branch_en && branch_taken) begin
                r_pc <= w_branchTarget;
            end else begin
                r_pc <= w_pcInc;
            end
        end
    end

    assign stack_count     = '0;
    assign stack_overflow  = 1'b0;
    assign stack_underflow = 1'b0;

`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//
// Self-checking bench for pc_sequencer with WIDTH=16, STACK_DEPTH=4 and
// RESET_VECTOR=0. Each stimulus step carries its expected outputs, and the
// expected value is queued at the moment the step is driven. After the
// clock edge the step's task pops that entry and compares it with the DUT.
// The bench follows PC_SEQUENCER_STACK_EN in the same way as the DUT. When
// the macro is undefined, calls act as jumps, returns act as increments,
// and all stack outputs are expected to read 0.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

`ifdef PC_SEQUENCER_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic        clk;
    logic        is_powered_on;
    logic        stall;
    logic        jump_en;
    logic [15:0] jump_target;
    logic        branch_en;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        call_en;
    logic        ret_en;
    logic [15:0] program_counter;
    logic [2:0]  stack_count;
    logic        stack_overflow;
    logic        stack_underflow;

    typedef struct packed {
        logic [15:0] pc;
        logic [2:0]  cnt;
        logic        ovf;
        logic        unf;
    } obs_t;

    typedef struct {
        bit          rstN;
        bit          stl;
        bit          jmp;
        logic [15:0] tgt;
        bit          br;
        bit          tk;
        logic [15:0] off;
        bit          cl;
        bit          rt;
        obs_t        exp;
    } stim_t;

    obs_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    pc_sequencer #(
        .WIDTH        (16),
        .STACK_DEPTH  (4),
        .RESET_VECTOR (16'h0000)
    ) dut (
        .clk             (clk),
        .is_powered_on   (is_powered_on),
        .stall           (stall),
        .jump_en         (jump_en),
        .jump_target     (jump_target),
        .branch_en       (branch_en),
        .branch_taken    (branch_taken),
        .branch_offset   (branch_offset),
        .call_en         (call_en),
        .ret_en          (ret_en),
        .program_counter (program_counter),
        .stack_count     (stack_count),
        .stack_overflow  (stack_overflow),
        .stack_underflow (stack_underflow)
    );

    // 10-time-unit clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Builds one stimulus step. The stack count and both flags are forced
    // to 0 when the build has no stack.
    function automatic stim_t mk(bit rstN, bit stl, bit jmp, logic [15:0] tgt,
                                 bit br, bit tk, logic [15:0] off, bit cl, bit rt,
                                 logic [15:0] pc, int cnt, bit ovf, bit unf);
        stim_t s;
        s.rstN    = rstN;
        s.stl     = stl;
        s.jmp     = jmp;
        s.tgt     = tgt;
        s.br      = br;
        s.tk      = tk;
        s.off     = off;
        s.cl      = cl;
        s.rt      = rt;
        s.exp.pc  = pc;
        s.exp.cnt = STK ? cnt[2:0] : 3'd0;
        s.exp.ovf = STK & ovf;
        s.exp.unf = STK & unf;
        return s;
    endfunction

    // Drives one step shortly after a rising edge, queues its expected
    // outputs, and then waits until 1 time unit past the next edge.
    task automatic applyStimulus(input stim_t s);
        is_powered_on = s.rstN;
        stall         = s.stl;
        jump_en       = s.jmp;
        jump_target   = s.tgt;
        branch_en     = s.br;
        branch_taken  = s.tk;
        branch_offset = s.off;
        call_en       = s.cl;
        ret_en        = s.rt;
        expQ.push_back(s.exp);
        @(posedge clk);
        #1;
    endtask

    // Reset, 3 idle increments, then reset held against stall and a jump.
    task automatic test_reset();
        stim_t steps[$];
        obs_t  obs, e;
        steps.push_back(mk(0,0,0,16'h0000,0,0,16'h0000,0,0, 16'h0000,0,0,0));
        steps.push_back(mk(1,0,0,16'h0000,0,0,16'h0000,0,0, 16'h0001,0,0,0));
        steps.push_back(mk(1,0,0,16'h0000,0,0,16'h0000,0,0, 16'h0002,0,0,0));
        steps.push_back(mk(1,0,0,16'h0000,0,0,16'h0000,0,0, 16'h0003,0,0,0));
        steps.push_back(mk(0,1,0,16'h0000,0,0,16'h0000,0,0, 16'h0000,0,0,0));
        steps.push_back(mk(0,1,0,16'h0000,0,0,16'h0000,0,0, 16'h0000,0,0,0));
        steps.push_back(mk(0,0,1,16'h1234,0,0,16'h0000,1,0, 16'h0000,0,0,0));
        foreach (steps[i]) begin
            applyStimulus(steps[i]);
            obs = {program_counter, stack_count, stack_overflow, stack_underflow};
            e   = expQ.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL reset step %0d: got pc=%h cnt=%0d ovf=%b unf=%b, want pc=%h cnt=%0d ovf=%b unf=%b",
                         i, obs.pc, obs.cnt, obs.ovf, obs.unf, e.pc, e.cnt, e.ovf, e.unf);
            end
        end
    endtask

    // Jump to all-ones, and the next increment wraps to 0.
    task automatic test_wrap();
        stim_t steps[$];
        obs_t  obs, e;
        steps.push_back(mk(1,0,1,16'hFFFF,0,0,16'h0000,0,0, 16'hFFFF,0,0,0));
        steps.push_back(mk(1,0,0,16'h0000,0,0,16'h0000,0,0, 16'h0000,0,0,0));
        steps.push_back(mk(1,0,0,16'h0000,0,0,16'h0000,0,0, 16'h0001,0,0,0));
        foreach (steps[i]) begin
            applyStimulus(steps[i]);
            obs = {program_counter, stack_count, stack_overflow, stack_underflow};
            e   = expQ.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL wrap step %0d: got pc=%h cnt=%0d ovf=%b unf=%b, want pc=%h cnt=%0d ovf=%b unf=%b",
                         i, obs.pc, obs.cnt, obs.ovf, obs.unf, e.pc, e.cnt, e.ovf, e.unf);
            end
        end
    endtask

    // Backward taken branch, not-taken branch, forward taken branch.
    task automatic test_branch();
        stim_t steps[$];
        obs_t  obs, e;
        steps.push_back(mk(1,0,1,16'h0010,0,0,16'h0000,0,0, 16'h0010,0,0,0));
        steps.push_back(mk(1,0,0,16'h0000,1,1,16'hFFF8,0,0, 16'h0008,0,0,0));
        steps.push_back(mk(1,0,1,16'h0010,0,0,16'h0000,0,0, 16'h0010,0,0,0));
        steps.push_back(mk(1,0,0,16'h0000,1,0,16'hFFF8,0,0, 16'h0011,0,0,0));
        steps.push_back(mk(1,0,0,16'h0000,1,1,16'h0005,0,0, 16'h0016,0,0,0));
        foreach (steps[i]) begin
            applyStimulus(steps[i]);
            obs = {program_counter, stack_count, stack_overflow, stack_underflow};
            e   = expQ.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL branch step %0d: got pc=%h cnt=%0d ovf=%b unf=%b, want pc=%h cnt=%0d ovf=%b unf=%b",
                         i, obs.pc, obs.cnt, obs.ovf, obs.unf, e.pc, e.cnt, e.ovf, e.unf);
            end
        end
    endtask

    // Two nested calls followed by two LIFO returns.
    task automatic test_call_ret();
        stim_t steps[$];
        obs_t  obs, e;
        steps.push_back(mk(1,0,1,16'h0020,0,0,16'h0000,0,0, 16'h0020,0,0,0));
        steps.push_back(mk(1,0,0,16'h0100,0,0,16'h0000,1,0, 16'h0100,1,0,0));
        steps.push_back(mk(1,0,0,16'h0200,0,0,16'h0000,1,0, 16'h0200,2,0,0));
        steps.push_back(mk(1,0,0,16'h0000,0,0,16'h0000,0,1, STK ? 16'h0101 : 16'h0201,1,0,0));
        steps.push_back(mk(1,0,0,16'h0000,0,0,16'h0000,0,1, STK ? 16'h0021 : 16'h0202,0,0,0));
        foreach (steps[i]) begin
            applyStimulus(steps[i]);
            obs = {program_counter, stack_count, stack_overflow, stack_underflow};
            e   = expQ.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL call_ret step %0d: got pc=%h cnt=%0d ovf=%b unf=%b, want pc=%h cnt=%0d ovf=%b unf=%b",
                         i, obs.pc, obs.cnt, obs.ovf, obs.unf, e.pc, e.cnt, e.ovf, e.unf);
            end
        end
    endtask

    // Five calls overflow the stack. Four returns drain it, one extra
    // return underflows it, a stall holds the sticky flags, and reset
    // clears them.
    task automatic test_overflow();
        stim_t steps[$];
        obs_t  obs, e;
        steps.push_back(mk(0,0,0,16'h0000,0,0,16'h0000,0,0, 16'h0000,0,0,0));
        steps.push_back(mk(1,0,0,16'h0300,0,0,16'h0000,1,0, 16'h0300,1,0,0));
        steps.push_back(mk(1,0,0,16'h0400,0,0,16'h0000,1,0, 16'h0400,2,0,0));
        steps.push_back(mk(1,0,0,16'h0500,0,0,16'h0000,1,0, 16'h0500,3,0,0));
        steps.push_back(mk(1,0,0,16'h0600,0,0,16'h0000,1,0, 16'h0600,4,0,0));
        steps.push_back(mk(1,0,0,16'h0700,0,0,16'h0000,1,0, 16'h0700,4,1,0));
        steps.push_back(mk(1,0,0,16'h0000,0,0,16'h0000,0,1, STK ? 16'h0501 : 16'h0701,3,1,0));
        steps.push_back(mk(1,0,0,16'h0000,0,0,16'h0000,0,1, STK ? 16'h0401 : 16'h0702,2,1,0));
        steps.push_back(mk(1,0,0,16'h0000,0,0,16'h0000,0,1, STK ? 16'h0301 : 16'h0703,1,1,0));
        steps.push_back(mk(1,0,0,16'h0000,0,0,16'h0000,0,1, STK ? 16'h0001 : 16'h0704,0,1,0));
        steps.push_back(mk(1,0,0,16'h0000,0,0,16'h0000,0,1, STK ? 16'h0002 : 16'h0705,0,1,1));
        steps.push_back(mk(1,1,1,16'h0AAA,0,0,16'h0000,1,0, STK ? 16'h0002 : 16'h0705,0,1,1));
        steps.push_back(mk(0,0,0,16'h0000,0,0,16'h0000,0,0, 16'h0000,0,0,0));
        foreach (steps[i]) begin
            applyStimulus(steps[i]);
            obs = {program_counter, stack_count, stack_overflow, stack_underflow};
            e   = expQ.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL overflow step %0d: got pc=%h cnt=%0d ovf=%b unf=%b, want pc=%h cnt=%0d ovf=%b unf=%b",
                         i, obs.pc, obs.cnt, obs.ovf, obs.unf, e.pc, e.cnt, e.ovf, e.unf);
            end
        end
    endtask

    // Simultaneous requests, stall over a jump, jump over a branch, and a
    // reset between a call and its return.
    task automatic test_priority();
        stim_t steps[$];
        obs_t  obs, e;
        steps.push_back(mk(0,0,0,16'h0000,0,0,16'h0000,0,0, 16'h0000,0,0,0));
        steps.push_back(mk(1,0,0,16'h0040,0,0,16'h0000,1,0, 16'h0040,1,0,0));
        steps.push_back(mk(1,0,1,16'h0080,0,0,16'h0000,1,1, STK ? 16'h0001 : 16'h0041,0,0,0));
        steps.push_back(mk(1,1,1,16'h0090,0,0,16'h0000,0,0, STK ? 16'h0001 : 16'h0041,0,0,0));
        steps.push_back(mk(1,0,1,16'h0090,1,1,16'h0010,0,0, 16'h0090,0,0,0));
        steps.push_back(mk(1,0,0,16'h0050,0,0,16'h0000,1,0, 16'h0050,1,0,0));
        steps.push_back(mk(0,0,0,16'h0000,0,0,16'h0000,0,1, 16'h0000,0,0,0));
        steps.push_back(mk(1,0,0,16'h0000,0,0,16'h0000,0,1, 16'h0001,0,0,1));
        foreach (steps[i]) begin
            applyStimulus(steps[i]);
            obs = {program_counter, stack_count, stack_overflow, stack_underflow};
            e   = expQ.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL priority step %0d: got pc=%h cnt=%0d ovf=%b unf=%b, want pc=%h cnt=%0d ovf=%b unf=%b",
                         i, obs.pc, obs.cnt, obs.ovf, obs.unf, e.pc, e.cnt, e.ovf, e.unf);
            end
        end
    endtask

    // Runs every scenario in order and prints the summary line.
    initial begin
        is_powered_on = 1'b0;
        stall         = 1'b0;
        jump_en       = 1'b0;
        jump_target   = '0;
        branch_en     = 1'b0;
        branch_taken  = 1'b0;
        branch_offset = '0;
        call_en       = 1'b0;
        ret_en        = 1'b0;
        $display("[TB] stack build = %0d", STK);
        test_reset();
        test_wrap();
        test_branch();
        test_call_ret();
        test_overflow();
        test_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clock port clk, reset port is_powered_on (0 = reset).
REQ-002 Parameters SHALL be:
- WIDTH, 16, program counter width in bits.
- STACK_DEPTH, 4, return-stack entries, at least 1.
- RESET_VECTOR, 0, PC value loaded on reset.
REQ-003 Ports SHALL be:
- clk  input  1  rising-edge clock.
- is_powered_on  input  1  synchronous active-low reset.
- stall  input  1  hold PC and stack.
- jump_en  input  1  absolute jump to jump_target.
- jump_target  input  WIDTH  absolute target address.
- branch_en  input  1  conditional relative branch request.
- branch_taken  input  1  branch condition result.
- branch_offset  input  WIDTH  two's-complement offset.
- call_en  input  1  push return address, go to jump_target.
- ret_en  input  1  pop return address into PC.
- program_counter  output  WIDTH  registered current PC.
- stack_count  output  clog2(STACK_DEPTH+1)  valid stack entries.
- stack_overflow  output  1  sticky; a call occurred while the stack was full.
- stack_underflow  output  1  sticky; a return occurred while the stack was empty.

Function
REQ-004 program_counter SHALL be registered; all inputs are sampled at the rising clk edge and the new PC is visible after that edge, one cycle of latency.
REQ-005 When not in reset, the next PC SHALL be selected by strict priority: stall > ret_en > call_en > jump_en > (branch_en and branch_taken) > increment.
REQ-006 stall=1 SHALL hold the PC, stack contents, stack_count and flags unchanged.
REQ-007 Increment SHALL be PC+1 modulo 2^WIDTH; all-ones wraps to 0 with no flag.
REQ-008 A taken branch SHALL load PC+branch_offset modulo 2^WIDTH, with the offset sign-interpreted.
REQ-009 branch_en=1 with branch_taken=0 SHALL increment.
REQ-010 A jump SHALL load jump_target.
REQ-011 A call SHALL push PC+1 (wrapped), increment stack_count and load jump_target.
REQ-012 A call while stack_count==STACK_DEPTH SHALL still load jump_target, SHALL NOT push or change stack_count, and SHALL set stack_overflow.
REQ-013 A return with stack_count>0 SHALL load the top entry and decrement stack_count (LIFO).
REQ-014 A return with stack_count==0 SHALL increment the PC instead and SHALL set stack_underflow.
REQ-015 When several requests are asserted in one cycle, only the highest-priority one SHALL take effect; lower requests are dropped, not queued.
REQ-016 stack_overflow and stack_underflow SHALL stay set until reset.

Reset
REQ-017 On a rising clk edge with is_powered_on=0 the block SHALL set:
- program_counter = RESET_VECTOR.
- stack_count = 0.
- stack_overflow = 0 and stack_underflow = 0.
REQ-018 Reset SHALL override stall and every other request.
REQ-019 Stack storage need not be cleared on reset; it is unreadable while stack_count is 0.
REQ-020 When reset is asserted mid-sequence, for example between a call and its return, the stack SHALL be discarded.
REQ-021 There SHALL be no asynchronous reset path.

Configuration
REQ-022 With macro PC_SEQUENCER_STACK_EN defined, the return stack and REQ-011 to REQ-014 SHALL be implemented.
REQ-023 Without PC_SEQUENCER_STACK_EN, no stack storage SHALL be built and:
- call_en SHALL behave as jump_en, at the same priority slot.
- ret_en SHALL behave as increment.
- stack_count, stack_overflow and stack_underflow SHALL be constant 0.

Verification
REQ-024 The bench SHALL cover, with WIDTH=16, STACK_DEPTH=4 and RESET_VECTOR=0 unless stated:
- Reset, then 3 idle cycles -> PC 0,1,2,3; hold reset with stall=1 -> PC stays 0.
- Drive PC to 0xFFFF, then idle -> PC wraps to 0x0000.
- PC=0x0010, branch_en=1, branch_taken=1, offset 0xFFF8 -> PC 0x0008; same request with branch_taken=0 -> PC 0x0011.
- From PC=0x0020, call to 0x0100; next cycle call to 0x0200; then ret, ret -> PC 0x0101 then 0x0021, stack_count 2,1,0 at each step.
- Five calls -> stack_count 4, stack_overflow=1 after the fifth call, PC = fifth target; one extra ret at count 0 -> PC+1, stack_underflow=1.
- Assert call_en, ret_en and jump_en together with count 1 -> the pop wins, count 0; stall=1 over a jump -> PC unchanged.
- Rebuild without PC_SEQUENCER_STACK_EN: call to 0x0100 -> PC 0x0100 and all stack outputs stay 0.
